dummy_accelerator_dispatcher: RTL and testbench
===============================================

// Module: dummy_accelerator_dispatcher
// PURPOSE
//  Generalised front-end for NUM_EU execution units (EUs) sharing one CPU-side request/response port.
//  Steers each request to the EU selected by ctl_i and records the issue order in an order FIFO.
//  Returns results strictly in issue order, for any mix of EU latencies. No restriction on switching EUs.
//  Illegal ctl_i values complete locally with an error response. Sits between the coprocessor interface and the EUs.
// PARAMETERS
//  WIDTH            32   result/operand width
//  NUM_EU           2    number of execution units (>=1); ctl_i value k selects EU k
//  MAX_OUTSTANDING  8    order-FIFO depth (power of two, >=2)
//  tag_type_t       logic  request tag (rd/id), returned with the result
// PORTS
//  clk_i        in   1                    clock; all state on posedge
//  rst_ni       in   1                    reset, synchronous, active-low
//  flush_i      in   1                    synchronous clear of all tracking state
//  valid_i      in   1                    request valid (upstream)
//  ready_o      out  1                    request accepted when valid_i&ready_o
//  ctl_i        in   CTL_W                EU selector, CTL_W=$clog2(NUM_EU) (min 1)
//  tag_i        in   tag_type_t           request tag
//  eu_valid_o   out  NUM_EU               per-EU request valid (one-hot or 0)
//  eu_ready_i   in   NUM_EU               per-EU request ready
//  eu_valid_i   in   NUM_EU               per-EU result valid
//  eu_ready_o   out  NUM_EU               per-EU result ready
//  eu_result_i  in   NUM_EU x WIDTH       per-EU result
//  eu_tag_i     in   NUM_EU x tag_type_t  per-EU result tag
//  valid_o      out  1                    response valid (downstream)
//  ready_i      in   1                    downstream ready
//  result_o     out  WIDTH                response data
//  tag_o        out  tag_type_t           response tag
//  err_o        out  1                    response is an illegal-ctl error
// BEHAVIOUR
//  Reset (rst_ni=0 at a clock edge): FIFO empty, pointers/count 0. Resulting outputs: ready_o=1, valid_o=0,
//   eu_valid_o=0, eu_ready_o=0, result_o=0, tag_o=0, err_o=0. Reset mid-operation drops all in-flight entries.
//  flush_i: same clearing as reset on the next edge. Takes priority over a same-cycle push/pop. EUs are flushed externally.
//  Illegal ctl: ctl_i>=NUM_EU.
//  Accept: ready_o = !full && (illegal || eu_ready_i[ctl_i]).
//   ready_o is independent of a same-cycle pop (no full-bypass).
//   eu_valid_o[ctl_i] = valid_i && !full && !illegal. Combinational, zero added latency.
//   ready_o may depend on valid_i-free inputs only; no comb path from valid_i to ready_o.
//  Push on accept: entry {eu_id=ctl_i, err=illegal, tag=tag_i}.
//  Head entry h (only when FIFO non-empty):
//   normal: valid_o = eu_valid_i[h.eu_id]; result_o/tag_o come from that EU; err_o=0;
//           eu_ready_o[h.eu_id] = ready_i; all other eu_ready_o = 0.
//   error : valid_o=1, result_o=0, tag_o=h.tag, err_o=1; all eu_ready_o=0.
//   empty : valid_o=0 and data outputs 0, regardless of eu_valid_i.
//  Pop on valid_o && ready_i.
//  Simultaneous push+pop: count unchanged; legal at full only because ready_o already excludes full.
//  Latency: no FIFO bypass. An entry pushed into an empty FIFO becomes head on the next cycle,
//   so the earliest response is 1 cycle after accept (error responses are exactly 1 cycle).
//  Pointers wrap modulo MAX_OUTSTANDING. count is $clog2(MAX_OUTSTANDING)+1 bits; full = (count==MAX_OUTSTANDING).
//  Once valid_o is asserted, result_o/tag_o/err_o are held stable until ready_i (AXI-style rule).
//  EU results not at head are back-pressured. Each EU must itself return its results in order.
//  Assertions: eu_valid_o is onehot0. count never exceeds MAX_OUTSTANDING.
// STRUCTURE
//  dummy_accelerator_pkg: add eu_id_t (CTL_W bits) and an order-entry struct template {eu_id, err}.
//   The tag field is added locally, because tag_type_t is a parameter.
//  Sub-module dummy_accelerator_order_fifo: sync FIFO with DEPTH and type parameters; push/pop/full/empty/head; flush input.
//  Top: accept logic, one-hot EU steering, head-indexed output mux.
// TESTING
//  1 Reset: hold rst_ni=0 3 cycles with valid_i=1.
//    -> ready_o=1, valid_o=0, eu_valid_o=0 throughout; after release the first request is accepted.
//  2 Order: NUM_EU=2. Issue tag 1->EU1 (latency 10), then tag 2->EU0 (latency 1).
//    -> EU0 result is held (eu_ready_o[0]=0) until tag 1 returns. Output order is tags 1, 2.
//  3 Full: MAX_OUTSTANDING=8, ready_i=0. Issue 9 requests.
//    -> the 9th sees ready_o=0. Raising ready_i for 1 cycle pops one entry; the 9th is accepted on the next cycle.
//  4 Illegal: NUM_EU=3, ctl_i=3, tag=5.
//    -> no eu_valid_o; the next cycle gives valid_o=1, err_o=1, result_o=0, tag_o=5.
//  5 Flush: 4 outstanding entries, flush_i for 1 cycle.
//    -> count=0, valid_o=0 on the next cycle. Stale eu_valid_i is ignored (empty FIFO).
//  6 Backpressure: ready_i toggles randomly during a 100-request mixed stream.
//    -> responses are stable while stalled; all tags are returned once each, in order.

Source files
------------

// File: rtl/dummy_accelerator_pkg.sv
`default_nettype none
// ============================================================================
// Module : dummy_accelerator_pkg
// Brief  : Shared types and helpers for the accelerator dispatcher.
// Rev    : 1.0
// ============================================================================
package dummy_accelerator_pkg;

   localparam int unsigned c_eu_id_w = 8;

   typedef logic [c_eu_id_w-1:0] eu_id_t;

   // Order-entry template; users append their own tag field around it.
   typedef struct packed {
      eu_id_t eu_id;
      logic   err;
   } order_entry_t;

   function automatic int unsigned ctl_width(input int unsigned num_eu);
      return (num_eu > 1) ? $clog2(num_eu) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dummy_accelerator_order_fifo.sv
`default_nettype none
// ============================================================================
// Module : dummy_accelerator_order_fifo
// Brief  : Synchronous issue-order FIFO with flush; head is visible without a pop.
// Rev    : 1.0
// ============================================================================
module dummy_accelerator_order_fifo #(
   parameter int unsigned DEPTH  = 8,
   parameter type         data_t = logic
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  flush_i,
   input  logic  push_i,
   input  data_t data_i,
   input  logic  pop_i,
   output data_t head_o,
   output logic  full_o,
   output logic  empty_o
);

   localparam int unsigned c_ptr_w = $clog2(DEPTH);
   localparam logic [c_ptr_w:0] c_full_cnt = (c_ptr_w + 1)'(DEPTH);

   data_t                r_mem [DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_ptr_w:0]     r_count;
   logic                 w_push;
   logic                 w_pop;

   assign full_o  = (r_count == c_full_cnt);
   assign empty_o = (r_count == '0);
   assign head_o  = r_mem[r_rd_ptr];

   assign w_push = push_i && !full_o  && rst_ni && !flush_i;
   assign w_pop  = pop_i  && !empty_o && rst_ni && !flush_i;

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   a_count_bound: assert property (@(posedge clk_i) r_count <= c_full_cnt);

endmodule
`default_nettype wire

// File: rtl/dummy_accelerator_dispatcher.sv
`default_nettype none
// ============================================================================
// Module : dummy_accelerator_dispatcher
// Brief  : Steers requests to NUM_EU execution units, returns results in issue order.
// Rev    : 1.0
// ============================================================================
module dummy_accelerator_dispatcher
   import dummy_accelerator_pkg::*;
#(
   parameter int unsigned WIDTH           = 32,
   parameter int unsigned NUM_EU          = 2,
   parameter int unsigned MAX_OUTSTANDING = 8,
   parameter type         tag_type_t      = logic
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          flush_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic [ctl_width(NUM_EU)-1:0]  ctl_i,
   input  tag_type_t                     tag_i,
   output logic [NUM_EU-1:0]             eu_valid_o,
   input  logic [NUM_EU-1:0]             eu_ready_i,
   input  logic [NUM_EU-1:0]             eu_valid_i,
   output logic [NUM_EU-1:0]             eu_ready_o,
   input  logic [NUM_EU-1:0][WIDTH-1:0]  eu_result_i,
   input  tag_type_t [NUM_EU-1:0]        eu_tag_i,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [WIDTH-1:0]              result_o,
   output tag_type_t                     tag_o,
   output logic                          err_o
);

   localparam int unsigned c_ctl_w = ctl_width(NUM_EU);

   typedef struct packed {
      tag_type_t    tag;
      order_entry_t base;
   } entry_t;

   entry_t w_push_entry;
   entry_t w_head;
   logic   w_illegal;
   logic   w_sel_ready;
   logic   w_issue;
   logic   w_full;
   logic   w_empty;
   logic   w_push;
   logic   w_pop;

   // Request side: ready_o never looks at valid_i, eu_valid_o is gated so EUs see nothing in reset/flush.
   always_comb begin
      w_illegal   = (32'(ctl_i) >= NUM_EU);
      w_issue     = rst_ni && !flush_i && valid_i && !w_full && !w_illegal;
      w_sel_ready = 1'b0;
      eu_valid_o  = '0;
      for (int k = 0; k < int'(NUM_EU); k++) begin
         if (ctl_i == c_ctl_w'(k)) begin
            w_sel_ready   = eu_ready_i[k];
            eu_valid_o[k] = w_issue;
         end
      end
   end

   assign ready_o = !w_full && (w_illegal || w_sel_ready);
   assign w_push  = valid_i && ready_o;

   always_comb begin
      w_push_entry            = '0;
      w_push_entry.tag        = tag_i;
      w_push_entry.base.err   = w_illegal;
      w_push_entry.base.eu_id = c_eu_id_w'(ctl_i);
   end

   dummy_accelerator_order_fifo #(
      .DEPTH  (MAX_OUTSTANDING),
      .data_t (entry_t)
   ) u_order_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (w_push),
      .data_i  (w_push_entry),
      .pop_i   (w_pop),
      .head_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   // Response side: only the EU owning the head entry is allowed to hand over its result.
   always_comb begin
      valid_o    = 1'b0;
      result_o   = '0;
      tag_o      = '0;
      err_o      = 1'b0;
      eu_ready_o = '0;
      if (!w_empty) begin
         if (w_head.base.err) begin
            valid_o = 1'b1;
            tag_o   = w_head.tag;
            err_o   = 1'b1;
         end else begin
            for (int k = 0; k < int'(NUM_EU); k++) begin
               if (w_head.base.eu_id == c_eu_id_w'(k)) begin
                  valid_o       = eu_valid_i[k];
                  result_o      = eu_result_i[k];
                  tag_o         = eu_tag_i[k];
                  eu_ready_o[k] = ready_i;
               end
            end
         end
      end
   end

   assign w_pop = valid_o && ready_i;

   a_eu_valid_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(eu_valid_o));

endmodule
`default_nettype wire

// File: tb/tb_dummy_accelerator_dispatcher.sv
`default_nettype none
// ============================================================================
// Module : tb_dummy_accelerator_dispatcher
// Brief  : Directed + randomized bench with behavioural EU and issue-order models.
// Rev    : 1.0
// ============================================================================
module tb_dummy_accelerator_dispatcher;

   typedef logic [7:0] tag_t;

   typedef struct {
      int   eu;
      logic err;
      tag_t tag;
   } ord_t;

   typedef struct {
      int          eu;
      tag_t        tag;
      logic [31:0] res;
      int          due;
   } eu_t;

   logic             clk = 1'b0;
   logic             rst_ni, flush_i, valid_i, ready_i;
   logic             ready_o, valid_o, err_o;
   logic [1:0]       ctl_i;
   tag_t             tag_i, tag_o;
   logic [2:0]       eu_valid_o, eu_ready_i, eu_valid_i, eu_ready_o;
   logic [2:0][31:0] eu_result_i;
   logic [2:0][7:0]  eu_tag_i;
   logic [31:0]      result_o;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   ord_t ordq[$];
   eu_t  euq[$];
   tag_t popped[$];
   int   last_due[3];
   int   lat[3];
   bit   rnd_lat = 0, rnd_eur = 0, stale = 0;
   bit   prev_stall = 0;
   logic [31:0] prev_res;
   tag_t prev_tag;
   logic prev_err;
   logic last_ready, last_valid, last_err, last_acc;
   logic [2:0] last_euv, last_eur;
   logic [31:0] last_res;
   tag_t last_tag;

   always #5 clk = ~clk;

   dummy_accelerator_dispatcher #(
      .WIDTH           (32),
      .NUM_EU          (3),
      .MAX_OUTSTANDING (8),
      .tag_type_t      (tag_t)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .ctl_i       (ctl_i),
      .tag_i       (tag_i),
      .eu_valid_o  (eu_valid_o),
      .eu_ready_i  (eu_ready_i),
      .eu_valid_i  (eu_valid_i),
      .eu_ready_o  (eu_ready_o),
      .eu_result_i (eu_result_i),
      .eu_tag_i    (eu_tag_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .result_o    (result_o),
      .tag_o       (tag_o),
      .err_o       (err_o)
   );

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   function automatic int eu_front(input int k);
      for (int i = 0; i < euq.size(); i++) if (euq[i].eu == k) return i;
      return -1;
   endfunction

   // One clock cycle: drive EU models, check against the reference, commit the model at the edge.
   task automatic cycle();
      int          fi, hk, due, l;
      bit          ill, efull, eready, evalid, eerr, acc, pop;
      logic [2:0]  eeuv, eeur;
      logic [31:0] eres;
      tag_t        etag;
      eu_ready_i = rnd_eur ? 3'($urandom) : 3'b111;
      for (int k = 0; k < 3; k++) begin
         fi = eu_front(k);
         if (stale) begin
            eu_valid_i[k] = 1'b1; eu_result_i[k] = $urandom; eu_tag_i[k] = 8'($urandom);
         end else if (fi >= 0 && euq[fi].due <= cyc) begin
            eu_valid_i[k] = 1'b1; eu_result_i[k] = euq[fi].res; eu_tag_i[k] = euq[fi].tag;
         end else begin
            eu_valid_i[k] = 1'b0; eu_result_i[k] = $urandom; eu_tag_i[k] = 8'($urandom);
         end
      end
      #1;
      ill    = (ctl_i == 2'd3);
      efull  = (ordq.size() >= 8);
      eready = !efull && (ill ? 1'b1 : eu_ready_i[ctl_i]);
      eeuv   = (rst_ni && !flush_i && valid_i && !efull && !ill) ? (3'b001 << ctl_i) : 3'b000;
      evalid = 0; eres = '0; etag = '0; eerr = 0; eeur = '0;
      if (ordq.size() > 0) begin
         if (ordq[0].err) begin
            evalid = 1; etag = ordq[0].tag; eerr = 1;
         end else begin
            hk     = ordq[0].eu;
            evalid = eu_valid_i[hk];
            eres   = eu_result_i[hk];
            etag   = eu_tag_i[hk];
            eeur[hk] = ready_i;
         end
      end
      chk("ready_o", ready_o, eready);
      chk("eu_valid_o", eu_valid_o, eeuv);
      chk("valid_o", valid_o, evalid);
      chk("result_o", result_o, eres);
      chk("tag_o", tag_o, etag);
      chk("err_o", err_o, eerr);
      chk("eu_ready_o", eu_ready_o, eeur);
      if (evalid) chk("issue_order_tag", tag_o, ordq[0].tag);
      if (prev_stall) begin
         chk("stall_result", result_o, prev_res);
         chk("stall_tag", tag_o, prev_tag);
         chk("stall_err", err_o, prev_err);
      end
      acc = rst_ni && !flush_i && valid_i && eready;
      pop = rst_ni && !flush_i && evalid && ready_i;
      last_ready = ready_o; last_euv = eu_valid_o; last_valid = valid_o; last_res = result_o;
      last_tag = tag_o; last_err = err_o; last_eur = eu_ready_o; last_acc = acc;
      if (!rst_ni || flush_i) begin
         ordq.delete(); euq.delete(); last_due = '{0, 0, 0}; prev_stall = 0;
      end else begin
         if (pop) begin
            popped.push_back(tag_o);
            if (!ordq[0].err) euq.delete(eu_front(ordq[0].eu));
            void'(ordq.pop_front());
         end
         if (acc) begin
            ordq.push_back('{eu: int'(ctl_i), err: ill, tag: tag_i});
            if (!ill) begin
               l   = rnd_lat ? int'($urandom_range(1, 6)) : lat[ctl_i];
               due = (cyc + l > last_due[ctl_i]) ? cyc + l : last_due[ctl_i];
               last_due[ctl_i] = due;
               euq.push_back('{eu: int'(ctl_i), tag: tag_i, res: $urandom, due: due});
            end
         end
         prev_stall = evalid && !ready_i;
         prev_res = eres; prev_tag = etag; prev_err = eerr;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain(input int budget);
      valid_i = 0; ready_i = 1;
      for (int i = 0; i < budget && ordq.size() > 0; i++) cycle();
      cycle();
      chk("drain_idle_valid", last_valid, 1'b0);
   endtask

   initial begin
      int issued;
      rst_ni = 0; flush_i = 0; valid_i = 1; ready_i = 0; ctl_i = 0; tag_i = 8'd0;
      eu_valid_i = '0; eu_ready_i = '1; eu_result_i = '0; eu_tag_i = '0;
      lat = '{1, 1, 1}; last_due = '{0, 0, 0};
      @(negedge clk);

      // Reset held with a pending request
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("rst_ready", last_ready, 1'b1);
         chk("rst_valid", last_valid, 1'b0);
         chk("rst_euv", last_euv, 3'b000);
      end
      rst_ni = 1; tag_i = 8'd9;
      cycle();
      chk("post_rst_ready", last_ready, 1'b1);
      chk("post_rst_euv", last_euv, 3'b001);
      drain(20);

      // Order across EUs with different latencies
      lat = '{1, 10, 1}; ready_i = 1; popped.delete();
      valid_i = 1; ctl_i = 1; tag_i = 8'd1; cycle();
      ctl_i = 0; tag_i = 8'd2; cycle();
      valid_i = 0; cycle(); cycle(); cycle();
      chk("order_hold_eu_ready", last_eur, 3'b010);
      drain(30);
      chk("order_count", popped.size(), 2);
      if (popped.size() == 2) begin
         chk("order_first", popped[0], 8'd1);
         chk("order_second", popped[1], 8'd2);
      end

      // Full FIFO blocks the 9th request, no full-bypass
      lat = '{1, 1, 1}; ready_i = 0; valid_i = 1;
      for (int i = 0; i < 8; i++) begin
         ctl_i = 2'(i % 2); tag_i = 8'(10 + i); cycle();
         chk("fill_accept", last_ready, 1'b1);
      end
      tag_i = 8'd18; cycle();
      chk("full_ready", last_ready, 1'b0);
      ready_i = 1; cycle();
      chk("full_no_bypass", last_ready, 1'b0);
      ready_i = 0; cycle();
      chk("full_accept_after_pop", last_ready, 1'b1);
      drain(40);

      // Illegal selector completes locally
      valid_i = 1; ctl_i = 3; tag_i = 8'd5; ready_i = 0; cycle();
      chk("illegal_no_euv", last_euv, 3'b000);
      chk("illegal_accepted", last_ready, 1'b1);
      valid_i = 0; ready_i = 1; cycle();
      chk("illegal_valid", last_valid, 1'b1);
      chk("illegal_err", last_err, 1'b1);
      chk("illegal_result", last_res, 32'd0);
      chk("illegal_tag", last_tag, 8'd5);
      drain(10);

      // Flush with four outstanding entries, then stale EU valids
      lat = '{20, 20, 20}; ready_i = 0; valid_i = 1;
      for (int i = 0; i < 4; i++) begin
         ctl_i = 2'(i); tag_i = 8'(30 + i); cycle();
      end
      valid_i = 0; flush_i = 1; cycle();
      flush_i = 0; stale = 1; ready_i = 1; cycle();
      chk("flush_valid", last_valid, 1'b0);
      chk("flush_result", last_res, 32'd0);
      chk("flush_eu_ready", last_eur, 3'b000);
      stale = 0; lat = '{2, 3, 1};

      // Reset mid-operation drops in-flight entries
      ready_i = 0; valid_i = 1;
      for (int i = 0; i < 3; i++) begin
         ctl_i = 2'(i); tag_i = 8'(40 + i); cycle();
      end
      valid_i = 0; rst_ni = 0; cycle();
      rst_ni = 1; cycle();
      chk("midrst_valid", last_valid, 1'b0);
      drain(10);

      // Randomized 100-request stream with random backpressure everywhere
      rnd_lat = 1; rnd_eur = 1; popped.delete(); issued = 0;
      for (int i = 0; i < 3000 && issued < 100; i++) begin
         valid_i = ($urandom_range(0, 3) != 0);
         ctl_i   = 2'($urandom_range(0, 3));
         tag_i   = 8'(issued);
         ready_i = 1'($urandom);
         cycle();
         if (last_acc) issued++;
      end
      chk("stream_issued", issued, 100);
      rnd_eur = 0;
      drain(500);
      chk("stream_count", popped.size(), 100);
      for (int i = 0; i < popped.size() && i < 100; i++) chk("stream_order", popped[i], 8'(i));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
